// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter
// Shares one single-ported, fixed-latency word memory between the instruction
// fetch (I) port and the load/store data (D) port. One access is in flight at
// a time; the owning port gets a one-cycle done pulse with the read data.
//
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   i_req/i_addr/i_kill   fetch request, byte address, taken-branch cancel
//   i_done/i_rdata        fetch completion pulse and instruction word
//   i_stall               i_req & ~i_done
//   d_req/d_we/d_addr/d_wdata  load/store request
//   d_done/d_rdata        data completion pulse and load data
//   d_stall               d_req & ~d_done
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  shared memory interface
//   busy                  arbiter is not idle
module riscv_mem_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  input  logic              i_kill,
  output logic              i_done,
  output logic [31:0]       i_rdata,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
  typedef enum logic {OWN_D, OWN_I} owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT - 1);

  state_t              state, state_nxt;
  owner_t              owner;
  logic                kill;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [2:0]          lat_cnt;
  logic [3:0]          starve_cnt;

  logic                i_eff;
  logic                grant_i, grant_d;

  // Byte-offset and upper address bits are not used by a word memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[1:0], i_addr[31:ADDR_W+2],
                              d_addr[1:0], d_addr[31:ADDR_W+2]};

  assign i_eff = i_req & ~i_kill;

  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        // D has priority unless I has lost STARVE_MAX arbitrations in a row.
        if (i_eff && (!d_req || starve_cnt == STARVE_LIM)) begin
          grant_i = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end
        if (grant_i || grant_d) state_nxt = ACCESS;
      end
      ACCESS:  state_nxt = (LAT_INIT == 3'd0) ? DONE : WAIT;
      WAIT:    if (lat_cnt == 3'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= OWN_D;
      kill       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;

      if (state_nxt == IDLE) begin
        kill <= 1'b0;
      end else if (state != IDLE && owner == OWN_I && i_kill) begin
        kill <= 1'b1;
      end

      if (grant_i || grant_d) begin
        owner   <= grant_i ? OWN_I : OWN_D;
        we_q    <= grant_d & d_we;
        addr_q  <= grant_i ? i_addr[ADDR_W+1:2] : d_addr[ADDR_W+1:2];
        wdata_q <= d_wdata;
      end

      if (grant_i) begin
        starve_cnt <= '0;
      end else if (grant_d && i_eff && starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + 4'd1;
      end

      if (state == ACCESS) begin
        lat_cnt <= LAT_INIT;
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt - 3'd1;
      end
    end
  end

  assign mem_en    = (state == ACCESS);
  assign mem_we    = (state == ACCESS) & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state != IDLE);

  // A kill arriving in the DONE cycle itself still suppresses the pulse.
  assign i_done  = (state == DONE) && (owner == OWN_I) && !kill && !i_kill;
  assign d_done  = (state == DONE) && (owner == OWN_D);
  assign i_rdata = i_done ? mem_rdata : '0;
  assign d_rdata = d_done ? mem_rdata : '0;
  assign i_stall = i_req & ~i_done;
  assign d_stall = d_req & ~d_done;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Testbench for riscv_mem_arbiter: a fixed-latency memory model drives
// mem_rdata; expected memory accesses and done pulses are queued as stimulus
// is applied and compared by a monitor on the falling clock edge.
module tb_riscv_mem_arbiter;

  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned MEM_LAT    = 2;
  localparam int unsigned STARVE_MAX = 4;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              i_req, i_kill, d_req, d_we;
  logic [31:0]       i_addr, d_addr, d_wdata;
  logic              i_done, i_stall, d_done, d_stall;
  logic [31:0]       i_rdata, d_rdata;
  logic              mem_en, mem_we, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;

  riscv_mem_arbiter #(
    .ADDR_W    (ADDR_W),
    .MEM_LAT   (MEM_LAT),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_kill   (i_kill),
    .i_done   (i_done),
    .i_rdata  (i_rdata),
    .i_stall  (i_stall),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_done   (d_done),
    .d_rdata  (d_rdata),
    .d_stall  (d_stall),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pat(input logic [9:0] a);
    return {16'hC0DE, 6'd0, a};
  endfunction

  // Memory model: background pattern until written; read data appears
  // MEM_LAT cycles after the mem_en cycle, random otherwise.
  logic [31:0] mem_arr [1024];
  bit          wr_flag [1024];
  logic [31:0] pipe [MEM_LAT];

  always @(posedge clock) begin
    if (mem_en) pipe[0] <= wr_flag[mem_addr] ? mem_arr[mem_addr] : pat(mem_addr);
    else        pipe[0] <= $urandom();
    for (int k = 1; k < MEM_LAT; k++) pipe[k] <= pipe[k-1];
    if (mem_en && mem_we) begin
      mem_arr[mem_addr] <= mem_wdata;
      wr_flag[mem_addr] <= 1'b1;
    end
  end
  assign mem_rdata = pipe[MEM_LAT-1];

  typedef struct {
    bit          we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    int unsigned cyc;
  } mem_rec_t;

  typedef struct {
    bit          port_i;
    bit          chk;
    logic [31:0] data;
    int unsigned cyc;
  } done_rec_t;

  mem_rec_t  mem_q[$];
  done_rec_t done_q[$];

  task automatic push_mem(input bit we, input logic [9:0] a, input logic [31:0] wd,
                          input int unsigned cy);
    mem_rec_t r;
    r.we = we; r.addr = a; r.wdata = wd; r.cyc = cy;
    mem_q.push_back(r);
  endtask

  task automatic push_done(input bit pi, input bit chk, input logic [31:0] d,
                           input int unsigned cy);
    done_rec_t r;
    r.port_i = pi; r.chk = chk; r.data = d; r.cyc = cy;
    done_q.push_back(r);
  endtask

  always @(negedge clock) begin : monitor
    mem_rec_t  m;
    done_rec_t e;
    if (reset_n) begin
      if (mem_en) begin
        if (mem_q.size() == 0) begin
          check_eq("mem_unexpected", 32'd1, 32'd0);
        end else begin
          m = mem_q.pop_front();
          check_eq("mem_cycle", cyc, m.cyc);
          check_eq("mem_we", {31'd0, mem_we}, {31'd0, m.we});
          check_eq("mem_addr", {22'd0, mem_addr}, {22'd0, m.addr});
          if (m.we) check_eq("mem_wdata", mem_wdata, m.wdata);
        end
      end else if (mem_we) begin
        check_eq("mem_we_unqualified", 32'd1, 32'd0);
      end
      if (i_done && d_done) check_eq("dual_done", 32'd1, 32'd0);
      if (i_done || d_done) begin
        if (done_q.size() == 0) begin
          check_eq("done_unexpected", {31'd0, i_done}, {31'd0, d_done});
        end else begin
          e = done_q.pop_front();
          check_eq("done_port_i", {31'd0, i_done}, {31'd0, e.port_i});
          check_eq("done_cycle", cyc, e.cyc);
          if (e.chk) check_eq("done_rdata", i_done ? i_rdata : d_rdata, e.data);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Waits for the given port's done pulse, checking its stall along the way,
  // then returns one clock later (the cycle after done).
  task automatic wait_done(input bit pi);
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clock);
      if (pi ? i_done : d_done) begin
        seen = 1'b1;
        check_eq(pi ? "i_stall_done" : "d_stall_done", {31'd0, pi ? i_stall : d_stall}, 32'd0);
      end else begin
        check_eq(pi ? "i_stall_wait" : "d_stall_wait", {31'd0, pi ? i_stall : d_stall}, 32'd1);
      end
    end
    if (!seen) check_eq(pi ? "i_done_timeout" : "d_done_timeout", 32'd0, 32'd1);
    tick(1);
  endtask

  task automatic lone_fetch();
    int unsigned c = cyc;
    i_req = 1'b1; i_addr = 32'h10;
    push_mem(1'b0, 10'd4, '0, c + 1);
    push_done(1'b1, 1'b1, pat(10'd4), c + 3);
    wait_done(1'b1);
    i_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int unsigned c;
    reset_n = 1'b0;
    i_req = 1'b0; i_kill = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    tick(2);
    check_eq("rst_busy",   {31'd0, busy},   32'd0);
    check_eq("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check_eq("rst_i_done", {31'd0, i_done}, 32'd0);
    check_eq("rst_d_done", {31'd0, d_done}, 32'd0);
    check_eq("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_i_rdata", i_rdata, 32'd0);
    check_eq("rst_d_rdata", d_rdata, 32'd0);
    check_eq("rst_i_stall", {31'd0, i_stall}, 32'd0);
    #2 reset_n = 1'b1;
    tick(1);

    lone_fetch();
    tick(1);

    // Starvation: D re-requests every IDLE cycle while I is held.
    c = cyc;
    i_req = 1'b1; i_addr = 32'h30;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      push_mem(1'b0, 10'(128 + k), '0, c + 1 + 4 * k);
      push_done(1'b0, 1'b1, pat(10'(128 + k)), c + 3 + 4 * k);
    end
    push_mem(1'b0, 10'd12, '0, c + 17);
    push_done(1'b1, 1'b1, pat(10'd12), c + 19);
    push_mem(1'b0, 10'd132, '0, c + 21);
    push_done(1'b0, 1'b1, pat(10'd132), c + 23);
    for (int k = 0; k < 4; k++) begin
      wait_done(1'b0);
      d_addr = 32'h200 + 32'(4 * (k + 1));
    end
    wait_done(1'b1);
    i_req = 1'b0;
    wait_done(1'b0);
    d_req = 1'b0;
    tick(1);

    // Simultaneous requests: D first, then I after one idle bubble.
    c = cyc;
    i_req = 1'b1; i_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    push_mem(1'b0, 10'd16, '0, c + 1);
    push_done(1'b0, 1'b1, pat(10'd16), c + 3);
    push_mem(1'b0, 10'd8, '0, c + 5);
    push_done(1'b1, 1'b1, pat(10'd8), c + 7);
    wait_done(1'b0);
    d_req = 1'b0;
    wait_done(1'b1);
    i_req = 1'b0;
    tick(1);

    // Kill during WAIT, with a D request queued behind it.
    c = cyc;
    i_req = 1'b1; i_addr = 32'h50;
    push_mem(1'b0, 10'd20, '0, c + 1);
    tick(2);
    i_kill = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60;
    push_mem(1'b0, 10'd24, '0, c + 5);
    push_done(1'b0, 1'b1, pat(10'd24), c + 7);
    tick(1);
    i_kill = 1'b0; i_req = 1'b0;
    tick(1);
    @(negedge clock);
    check_eq("kill_idle_busy", {31'd0, busy}, 32'd0);
    wait_done(1'b0);
    d_req = 1'b0;
    tick(1);

    // Kill arriving in the DONE cycle suppresses i_done.
    c = cyc;
    i_req = 1'b1; i_addr = 32'h70;
    push_mem(1'b0, 10'd28, '0, c + 1);
    tick(3);
    i_kill = 1'b1;
    tick(1);
    i_kill = 1'b0; i_req = 1'b0;
    tick(1);

    // Kill in IDLE blocks the grant for that cycle only.
    c = cyc;
    i_req = 1'b1; i_kill = 1'b1; i_addr = 32'h74;
    tick(1);
    i_kill = 1'b0;
    push_mem(1'b0, 10'd29, '0, c + 2);
    push_done(1'b1, 1'b1, pat(10'd29), c + 4);
    wait_done(1'b1);
    i_req = 1'b0;
    tick(1);

    // Store, then read it back.
    c = cyc;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'hDEADBEEF;
    push_mem(1'b1, 10'd2, 32'hDEADBEEF, c + 1);
    push_done(1'b0, 1'b0, '0, c + 3);
    wait_done(1'b0);
    d_req = 1'b0; d_we = 1'b0;
    tick(1);
    c = cyc;
    d_req = 1'b1; d_addr = 32'h8;
    push_mem(1'b0, 10'd2, '0, c + 1);
    push_done(1'b0, 1'b1, 32'hDEADBEEF, c + 3);
    wait_done(1'b0);
    d_req = 1'b0;
    tick(1);

    // Asynchronous reset in the middle of WAIT.
    c = cyc;
    i_req = 1'b1; i_addr = 32'h10;
    push_mem(1'b0, 10'd4, '0, c + 1);
    tick(2);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rstw_busy",   {31'd0, busy},   32'd0);
    check_eq("rstw_mem_en", {31'd0, mem_en}, 32'd0);
    check_eq("rstw_i_done", {31'd0, i_done}, 32'd0);
    check_eq("rstw_d_done", {31'd0, d_done}, 32'd0);
    i_req = 1'b0;
    tick(2);
    #2 reset_n = 1'b1;
    tick(1);
    lone_fetch();

    tick(3);
    check_eq("sb_mem_left",  32'(mem_q.size()),  32'd0);
    check_eq("sb_done_left", 32'(done_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
